majority_vote_controller: RTL

MAJORITY_VOTE_CONTROLLER -- requirements
Module: majority_vote_controller

---
 rtl/majority_vote_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/majority_vote_controller.sv
// rtl/majority_vote_controller.sv - four-voter round-robin majority vote controller
// Optional collect-phase timeout is enabled by defining MAJORITY_TIMEOUT_EN.

module majority_vote_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] vote_valid,
   input  logic [3:0] vote,
   output logic [3:0] vote_ack,
   output logic       result,
   output logic       result_valid,
   input  logic       result_ready,
   output logic       busy,
   output logic [2:0] vote_cnt,
   output logic       timed_out
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_EVAL    = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] rcvd_q, rcvd_d;
   logic [3:0] votes_q, votes_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] ptr_q, ptr_d;
   logic       result_q, result_d;

   logic [3:0] pending;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_found;
   logic [1:0] scan_idx;
   logic       last_vote;
   logic       expire;
   logic [2:0] ones;

`ifdef MAJORITY_TIMEOUT_EN
   localparam logic [7:0] TMR_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmr_q, tmr_d;
   logic       timed_out_q, timed_out_d;
`endif

   // Round-robin arbiter: first pending voter at or after the pointer wins.
   always_comb begin
      pending     = vote_valid & ~rcvd_q;
      grant       = 4'b0000;
      grant_idx   = 2'd0;
      grant_found = 1'b0;
      scan_idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr_q + 2'(k);
         if (!grant_found && pending[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
      if (grant_found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign last_vote = grant_found && (cnt_q == 3'd3);

`ifdef MAJORITY_TIMEOUT_EN
   assign expire = !last_vote && (tmr_q == TMR_LAST);
`else
   assign expire = 1'b0;
`endif

   assign ones = {2'b00, votes_q[0]} + {2'b00, votes_q[1]}
               + {2'b00, votes_q[2]} + {2'b00, votes_q[3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rcvd_q   <= 4'b0000;
         votes_q  <= 4'b0000;
         cnt_q    <= 3'd0;
         ptr_q    <= 2'd0;
         result_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rcvd_q   <= rcvd_d;
         votes_q  <= votes_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         result_q <= result_d;
      end
   end

`ifdef MAJORITY_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q       <= 8'd0;
         timed_out_q <= 1'b0;
      end else begin
         tmr_q       <= tmr_d;
         timed_out_q <= timed_out_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_COLLECT;
         S_COLLECT: if (last_vote || expire) state_d = S_EVAL;
         S_EVAL:    state_d = S_HOLD;
         S_HOLD:    if (result_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rcvd_d   = rcvd_q;
      votes_d  = votes_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      result_d = result_q;
`ifdef MAJORITY_TIMEOUT_EN
      tmr_d       = tmr_q;
      timed_out_d = timed_out_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rcvd_d  = 4'b0000;
               votes_d = 4'b0000;
               cnt_d   = 3'd0;
               ptr_d   = 2'd0;
`ifdef MAJORITY_TIMEOUT_EN
               tmr_d       = 8'd0;
               timed_out_d = 1'b0;
`endif
            end
         end
         S_COLLECT: begin
            if (grant_found) begin
               rcvd_d             = rcvd_q | grant;
               votes_d[grant_idx] = vote[grant_idx];
               cnt_d              = cnt_q + 3'd1;
               ptr_d              = grant_idx + 2'd1;
            end
`ifdef MAJORITY_TIMEOUT_EN
            tmr_d = tmr_q + 8'd1;
            if (expire) begin
               timed_out_d = 1'b1;
            end
`endif
         end
         S_EVAL: begin
            // Missing votes were cleared to 0 at start, so a 2-2 tie resolves to 0.
            result_d = (ones >= 3'd3);
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      vote_ack     = 4'b0000;
      result_valid = 1'b0;
      busy         = 1'b1;
      case (state_q)
         S_IDLE:    busy = 1'b0;
         S_COLLECT: vote_ack = grant;
         S_HOLD:    result_valid = 1'b1;
         default:   begin
         end
      endcase
   end

   assign result   = result_q;
   assign vote_cnt = cnt_q;

`ifdef MAJORITY_TIMEOUT_EN
   assign timed_out = timed_out_q;
`else
   assign timed_out = 1'b0;
`endif

endmodule
